complex_divider: RTL and testbench

- Sequential complex divider. Inverse operation of the team's complex multiplier: Q = N / D.
- Operands use the same packed 16-bit format: {re[7:0], im[7:0]}, each component signed two's complement.
- Result is a fixed-point complex quotient computed by an iterative restoring divider, one quotient bit per cycle.
- Sits between the multiplier datapath and downstream equalisation logic, with a valid/ready handshake on each side.

---
 rtl/complex_pkg.sv | 33 +++
 rtl/serial_udivider.sv | 73 +++++++
 rtl/complex_divider.sv | 158 +++++++++++++++
 tb/tb_complex_divider.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// Shared complex-number types and helpers for the multiplier/divider datapath.
// Operand words are {re, im} with signed 8-bit components.
package complex_pkg;

    localparam int COMPONENT_W = 8;
    localparam int OUT_W       = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DIVIDE,
        DONE
    } state_t;

    typedef struct packed {
        logic signed [COMPONENT_W-1:0] re;
        logic signed [COMPONENT_W-1:0] im;
    } cpx_t;

    function automatic cpx_t unpack_cpx(input logic [2*COMPONENT_W-1:0] word);
        return cpx_t'(word);
    endfunction

    function automatic logic [2*COMPONENT_W-1:0] pack_cpx(input cpx_t value);
        return {value.re, value.im};
    endfunction

    function automatic logic [2*OUT_W-1:0] pack_quot(input logic [OUT_W-1:0] re,
                                                     input logic [OUT_W-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/serial_udivider.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle already resolves the MSB.
// done rises DIVIDEND_W edges after start (start edge included) and holds until the next start.
module serial_udivider #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [DIVIDEND_W-1:0] r_work;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [DIVISOR_W-1:0]  w_rem_in;
    logic [DIVISOR_W-1:0]  w_div_in;
    logic [DIVIDEND_W-1:0] w_work_in;
    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_trial;
    logic                  w_qbit;
    logic [DIVISOR_W-1:0]  w_rem_nxt;

    // r_work shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        w_rem_in  = start ? '0 : r_rem;
        w_work_in = start ? dividend : r_work;
        w_div_in  = start ? divisor : r_div;
        w_shift   = {w_rem_in, w_work_in[DIVIDEND_W-1]};
        w_trial   = w_shift - {1'b0, w_div_in};
        w_qbit    = ~w_trial[DIVISOR_W];
        w_rem_nxt = w_qbit ? w_trial[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start || r_busy) begin
            r_rem  <= w_rem_nxt;
            r_div  <= w_div_in;
            r_work <= {w_work_in[DIVIDEND_W-2:0], w_qbit};
            if (start) begin
                r_cnt  <= CNT_W'(DIVIDEND_W - 1);
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_work;
    assign done     = r_done;

endmodule

// File: rtl/complex_divider.sv
// Sequential complex divider Q = N / D with sign-magnitude restoring division and saturation.
// OutValid rises NITER+2 edges from the accepting edge (2 when D == 0) and holds until OutReady.
module complex_divider
    import complex_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = complex_pkg::OUT_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [2*COMPONENT_W-1:0] InputDividend,
    input  logic [2*COMPONENT_W-1:0] InputDivisor,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [2*OUT_W-1:0]       QuotientResult,
    output logic                     DivByZero,
    output logic                     Overflow
);

    localparam int NITER = 16 + FRAC_BITS;
    localparam int MAG_W = 2 * COMPONENT_W;
    localparam logic [NITER-1:0] POS_LIM = NITER'((1 << (OUT_W - 1)) - 1);
    localparam logic [NITER-1:0] NEG_LIM = NITER'(1 << (OUT_W - 1));

    state_t             r_state;
    state_t             w_next_state;
    cpx_t               r_num;
    cpx_t               r_den;
    logic [2*OUT_W-1:0] r_quot;
    logic               r_dbz;
    logic               r_ovf;

    logic signed [COMPONENT_W-1:0] w_a, w_b, w_c, w_d;
    logic signed [MAG_W-1:0]       w_ac, w_bd, w_bc, w_ad, w_cc, w_dd;
    logic signed [MAG_W:0]         w_re_num, w_im_num;
    logic [MAG_W-1:0]              w_den, w_re_mag, w_im_mag;
    logic                          w_den_zero, w_accept, w_start;
    logic                          w_re_done, w_im_done, w_div_done;
    logic [NITER-1:0]              w_re_q, w_im_q;
    logic [OUT_W:0]                w_re_sat, w_im_sat;

    function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W:0] v);
        return v[MAG_W] ? (~v[MAG_W-1:0] + 1'b1) : v[MAG_W-1:0];
    endfunction

    // Returns {saturated, value}; the negative range reaches one step further than the positive.
    function automatic logic [OUT_W:0] saturate(input logic neg, input logic [NITER-1:0] mag);
        logic [OUT_W-1:0] lo;
        lo = mag[OUT_W-1:0];
        if (!neg && mag > POS_LIM) return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        if (neg && mag > NEG_LIM)  return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        return {1'b0, neg ? (~lo + 1'b1) : lo};
    endfunction

    assign w_a = r_num.re;
    assign w_b = r_num.im;
    assign w_c = r_den.re;
    assign w_d = r_den.im;

    // N * conj(D) / |D|^2
    assign w_ac       = w_a * w_c;
    assign w_bd       = w_b * w_d;
    assign w_bc       = w_b * w_c;
    assign w_ad       = w_a * w_d;
    assign w_cc       = w_c * w_c;
    assign w_dd       = w_d * w_d;
    assign w_re_num   = {w_ac[MAG_W-1], w_ac} + {w_bd[MAG_W-1], w_bd};
    assign w_im_num   = {w_bc[MAG_W-1], w_bc} - {w_ad[MAG_W-1], w_ad};
    assign w_den      = $unsigned(w_cc) + $unsigned(w_dd);
    assign w_den_zero = (w_den == '0);
    assign w_re_mag   = magnitude(w_re_num);
    assign w_im_mag   = magnitude(w_im_num);
    assign w_div_done = w_re_done & w_im_done;
    assign w_re_sat   = saturate(w_re_num[MAG_W], w_re_q);
    assign w_im_sat   = saturate(w_im_num[MAG_W], w_im_q);

    serial_udivider #(
        .DIVIDEND_W(NITER),
        .DIVISOR_W (MAG_W)
    ) u_re_div (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (w_start),
        .dividend({w_re_mag, {FRAC_BITS{1'b0}}}),
        .divisor (w_den),
        .quotient(w_re_q),
        .done    (w_re_done)
    );

    serial_udivider #(
        .DIVIDEND_W(NITER),
        .DIVISOR_W (MAG_W)
    ) u_im_div (
        .Clk     (Clk),
        .Reset   (Reset),
        .start   (w_start),
        .dividend({w_im_mag, {FRAC_BITS{1'b0}}}),
        .divisor (w_den),
        .quotient(w_im_q),
        .done    (w_im_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (InValid)    w_next_state = SETUP;
            SETUP:   w_next_state = w_den_zero ? DONE : DIVIDE;
            DIVIDE:  if (w_div_done) w_next_state = DONE;
            DONE:    if (OutReady)   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        InReady  = (r_state == IDLE);
        OutValid = (r_state == DONE);
        w_accept = InReady && InValid;
        w_start  = (r_state == SETUP) && !w_den_zero;
    end

    // Operands stay registered for the whole operation so signs remain valid at the final edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_num  <= '0;
            r_den  <= '0;
            r_quot <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_num <= unpack_cpx(InputDividend);
                r_den <= unpack_cpx(InputDivisor);
            end
            if (r_state == SETUP && w_den_zero) begin
                r_quot <= '0;
                r_dbz  <= 1'b1;
                r_ovf  <= 1'b0;
            end
            if (r_state == DIVIDE && w_div_done) begin
                r_quot <= pack_quot(w_re_sat[OUT_W-1:0], w_im_sat[OUT_W-1:0]);
                r_dbz  <= 1'b0;
                r_ovf  <= w_re_sat[OUT_W] | w_im_sat[OUT_W];
            end
        end
    end

    assign QuotientResult = r_quot;
    assign DivByZero      = r_dbz;
    assign Overflow       = r_ovf;

endmodule

// File: tb/tb_complex_divider.sv
// Directed bench for complex_divider; edge counts include the accepting edge as edge 1.
module tb_complex_divider;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [15:0] InputDividend;
    logic [15:0] InputDivisor;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] QuotientResult;
    logic        DivByZero;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    complex_divider dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .InValid       (InValid),
        .InReady       (InReady),
        .InputDividend (InputDividend),
        .InputDivisor  (InputDivisor),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .QuotientResult(QuotientResult),
        .DivByZero     (DivByZero),
        .Overflow      (Overflow)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Presents one pair while idle and waits (bounded) for OutValid; edges = -1 on timeout.
    task automatic issue(input logic [15:0] n, input logic [15:0] d, output int edges);
        @(negedge Clk);
        InputDividend = n;
        InputDivisor  = d;
        InValid       = 1'b1;
        @(posedge Clk);
        edges = 1;
        @(negedge Clk);
        InValid = 1'b0;
        while (!OutValid && edges < 100) begin
            @(posedge Clk);
            edges++;
            @(negedge Clk);
        end
        if (!OutValid) edges = -1;
    endtask

    task automatic consume();
        OutReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        InputDividend = '0; InputDivisor = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", InReady); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
        checks++; if (QuotientResult !== 32'h0) begin errors++; $display("FAIL reset_q got %h want 0", QuotientResult); end
        checks++; if ({DivByZero, Overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {DivByZero, Overflow}); end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int e;
        issue(16'h0402, 16'h0101, e);
        checks++; if (e !== 26) begin errors++; $display("FAIL basic_latency got %0d want 26", e); end
        checks++; if (QuotientResult !== 32'h0300FF00) begin errors++; $display("FAIL basic_q got %h want 0300ff00", QuotientResult); end
        checks++; if ({DivByZero, Overflow} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {DivByZero, Overflow}); end
        consume();
        checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin errors++; $display("FAIL basic_return_idle got rdy=%b vld=%b want 1 0", InReady, OutValid); end
    endtask

    task automatic test_neg_extremes();
        int e;
        issue(16'h8000, 16'h8000, e);
        checks++; if (e !== 26) begin errors++; $display("FAIL negext_latency got %0d want 26", e); end
        checks++; if (QuotientResult !== 32'h01000000) begin errors++; $display("FAIL negext_q got %h want 01000000", QuotientResult); end
        checks++; if ({DivByZero, Overflow} !== 2'b00) begin errors++; $display("FAIL negext_flags got %b want 00", {DivByZero, Overflow}); end
        consume();
    endtask

    task automatic test_saturation();
        int e;
        issue(16'h8000, 16'hFF00, e);
        checks++; if (QuotientResult !== 32'h7FFF0000) begin errors++; $display("FAIL sat_q got %h want 7fff0000", QuotientResult); end
        checks++; if ({DivByZero, Overflow} !== 2'b01) begin errors++; $display("FAIL sat_flags got %b want 01", {DivByZero, Overflow}); end
        consume();
    endtask

    task automatic test_div_zero();
        int e;
        issue(16'h1234, 16'h0000, e);
        checks++; if (e !== 2) begin errors++; $display("FAIL dbz_latency got %0d want 2", e); end
        checks++; if (QuotientResult !== 32'h0) begin errors++; $display("FAIL dbz_q got %h want 0", QuotientResult); end
        checks++; if ({DivByZero, Overflow} !== 2'b10) begin errors++; $display("FAIL dbz_flags got %b want 10", {DivByZero, Overflow}); end
        consume();
    endtask

    // Truncation toward zero, the exact -128 boundary and imaginary-side saturation.
    task automatic test_vectors();
        logic [15:0] vn [6];
        logic [15:0] vd [6];
        logic [31:0] vq [6];
        logic        vo [6];
        int e;
        vn = '{16'h0100, 16'hFF00, 16'h7F00, 16'h8000, 16'h8000, 16'h0305};
        vd = '{16'h0300, 16'h0300, 16'h0001, 16'h0100, 16'h0001, 16'h02FF};
        vq = '{32'h00550000, 32'hFFAB0000, 32'h00008100, 32'h80000000, 32'h00007FFF, 32'h00330299};
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(vn[i], vd[i], e);
            checks++; if (e !== 26) begin errors++; $display("FAIL vec%0d_latency got %0d want 26", i, e); end
            checks++; if (QuotientResult !== vq[i]) begin errors++; $display("FAIL vec%0d_q got %h want %h", i, QuotientResult, vq[i]); end
            checks++; if ({DivByZero, Overflow} !== {1'b0, vo[i]}) begin errors++; $display("FAIL vec%0d_flags got %b want %b", i, {DivByZero, Overflow}, {1'b0, vo[i]}); end
            consume();
        end
        issue(16'hF903, 16'hFDFE, e);
        checks++; if (QuotientResult !== 32'h0127FE3C) begin errors++; $display("FAIL vec_mixed_q got %h want 0127fe3c", QuotientResult); end
        consume();
    endtask

    task automatic test_back_to_back();
        int e;
        int bad_stable = 0;
        issue(16'h0100, 16'h0300, e);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (OutValid !== 1'b1 || InReady !== 1'b0 || QuotientResult !== 32'h00550000) bad_stable++;
        end
        checks++; if (bad_stable !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad_stable); end
        OutReady = 1'b1;
        InputDividend = 16'h0402; InputDivisor = 16'h0101; InValid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        OutReady = 1'b0;
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL b2b_after_hs got vld=%b rdy=%b want 0 1", OutValid, InReady); end
        @(posedge Clk);
        e = 1;
        @(negedge Clk);
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL b2b_accept got rdy=%b want 0", InReady); end
        // Keep junk on the inputs while busy; it must be ignored.
        InputDividend = 16'hFFFF; InputDivisor = 16'h7F7F;
        while (!OutValid && e < 100) begin
            @(posedge Clk);
            e++;
            @(negedge Clk);
        end
        InValid = 1'b0;
        checks++; if (e !== 26) begin errors++; $display("FAIL b2b_latency got %0d want 26", e); end
        checks++; if (QuotientResult !== 32'h0300FF00) begin errors++; $display("FAIL b2b_q got %h want 0300ff00", QuotientResult); end
        consume();
    endtask

    task automatic test_reset_mid_divide();
        int e;
        int stale = 0;
        @(negedge Clk);
        InputDividend = 16'h0402; InputDivisor = 16'h0101; InValid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        InValid = 1'b0;
        @(posedge Clk);
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        checks++; if (InReady !== 1'b0 || OutValid !== 1'b0) begin errors++; $display("FAIL mid_busy got rdy=%b vld=%b want 0 0", InReady, OutValid); end
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin errors++; $display("FAIL mid_reset got rdy=%b vld=%b want 1 0", InReady, OutValid); end
        checks++; if (QuotientResult !== 32'h0) begin errors++; $display("FAIL mid_reset_q got %h want 0", QuotientResult); end
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (OutValid !== 1'b0) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d valid cycles want 0", stale); end
        issue(16'hFF00, 16'h0300, e);
        checks++; if (e !== 26) begin errors++; $display("FAIL post_reset_latency got %0d want 26", e); end
        checks++; if (QuotientResult !== 32'hFFAB0000) begin errors++; $display("FAIL post_reset_q got %h want ffab0000", QuotientResult); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_extremes();
        test_saturation();
        test_div_zero();
        test_vectors();
        test_back_to_back();
        test_reset_mid_divide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
